pbit_update: RTL and testbench

- Downstream neighbour of the J*m+h MAC stage.
- Takes the signed local field I, scales it by an annealed inverse temperature beta, and clamps it (a hard-tanh approximation).
- Compares the result against an LFSR uniform random number to produce the new p-bit state m (1 = +1, 0 = -1).
- m feeds back to the MAC's m_in vector. Streaming, no backpressure; beta schedule runs internally.

---
 rtl/pbit_update_pkg.sv | 24 ++
 rtl/pbit_lfsr.sv | 29 ++
 rtl/pbit_update.sv | 172 +++++++++++++++++
 tb/tb_pbit_update.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pbit_update_pkg.sv
// pbit_update_pkg: shared constants and helpers for the p-bit update slice.
//   MAC_TO_BETA  : width of the signed J*m+h field produced by the MAC stage.
//   BETA_W/FRAC  : default beta width and its fractional bits (16 = 1.0).
//   RND_W        : default random/activation resolution (must be <= 16).
//   LFSR_W/TAPS  : 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
//   lfsr_next()  : one shift-left step of that LFSR, feedback into bit 0.
package pbit_update_pkg;

  localparam int MAC_TO_BETA   = 16;
  localparam int BETA_W_DEF    = 8;
  localparam int BETA_FRAC_DEF = 4;
  localparam int RND_W_DEF     = 12;

  localparam int LFSR_W = 16;
  // Tap mask selects state bits 15, 13, 12 and 10 (polynomial exponents 16, 14, 13, 11).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] state);
    logic fb;
    fb = ^(state & LFSR_TAPS);
    return {state[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/pbit_lfsr.sv
// pbit_lfsr: 16-bit Fibonacci LFSR that steps only when asked to, so its output
// sequence is a function of the number of advances since reset.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, loads seed
//   adv   : advance one step this cycle
//   seed  : reset value, must be nonzero
//   state : current LFSR state
module pbit_lfsr
  import pbit_update_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  // LFSR state register: load seed on reset, step on adv, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= seed;
    end else if (adv) begin
      state <= lfsr_next(state);
    end else begin
      state <= state;
    end
  end

endmodule

// File: rtl/pbit_update.sv
// pbit_update: probabilistic-bit update stage following the J*m+h MAC.
// Scales the signed field by an annealed beta, clamps it (hard-tanh), and
// compares it with an LFSR uniform sample to produce the new spin state.
// Three-stage pipeline, one sample per cycle, no backpressure.
//   clk            : rising-edge clock
//   rst_n          : synchronous active-low reset
//   in_valid       : in_data valid this cycle
//   in_data        : signed field I = J*m+h
//   anneal_restart : pulse, returns beta to BETA_INIT next cycle
//   m_out          : p-bit state, 1 = +1, 0 = -1
//   out_valid      : m_out updated this cycle
//   beta_out       : current beta register, for debug/status
module pbit_update
  import pbit_update_pkg::*;
#(
  parameter int                IN_W          = MAC_TO_BETA,
  parameter int                BETA_W        = BETA_W_DEF,
  parameter int                BETA_FRAC     = BETA_FRAC_DEF,
  parameter int                RND_W         = RND_W_DEF,
  parameter int                BETA_INIT     = 16,
  parameter int                BETA_STEP     = 4,
  parameter int                BETA_MAX      = 255,
  parameter int                ANNEAL_PERIOD = 256,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  input  logic              anneal_restart,
  output logic              m_out,
  output logic              out_valid,
  output logic [BETA_W-1:0] beta_out
);

  localparam int PROD_W = IN_W + BETA_W + 1;
  localparam int CNT_W  = (ANNEAL_PERIOD > 1) ? $clog2(ANNEAL_PERIOD) : 1;

  // Clamp bounds of the activation, +/- 2^(RND_W-1), held in RND_W+1 signed bits.
  localparam logic signed [RND_W:0]    ACT_HI   = (RND_W+1)'(2**(RND_W-1));
  localparam logic signed [RND_W:0]    ACT_LO   = -ACT_HI;
  localparam logic signed [PROD_W-1:0] WIDE_HI  = PROD_W'(2**(RND_W-1));
  localparam logic signed [PROD_W-1:0] WIDE_LO  = -WIDE_HI;
  localparam logic [BETA_W-1:0]        BETA_RST = BETA_W'(BETA_INIT);
  localparam logic [BETA_W:0]          STEP_EXT = (BETA_W+1)'(BETA_STEP);
  localparam logic [BETA_W:0]          MAX_EXT  = (BETA_W+1)'(BETA_MAX);
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(ANNEAL_PERIOD-1);

  logic [BETA_W-1:0]        beta_r;
  logic [CNT_W-1:0]         cnt_r;
  logic [BETA_W:0]          beta_sum_s;
  logic [BETA_W-1:0]        beta_next_s;

  logic signed [PROD_W-1:0] in_ext_s;
  logic signed [PROD_W-1:0] beta_ext_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [PROD_W-1:0] scaled_s;
  logic signed [PROD_W-1:0] scaled_r;
  logic                     v1_r;

  logic signed [RND_W:0]    act_s;
  logic signed [RND_W:0]    act_r;
  logic                     v2_r;

  logic [LFSR_W-1:0]        lfsr_s;
  logic signed [RND_W:0]    rnd_s;
  logic                     unused_s;

  assign beta_out = beta_r;

  // Beta step with one spare bit so the sum saturates at BETA_MAX instead of wrapping.
  always_comb begin
    beta_sum_s  = {1'b0, beta_r} + STEP_EXT;
    beta_next_s = beta_r;
    if (beta_sum_s > MAX_EXT) begin
      beta_next_s = MAX_EXT[BETA_W-1:0];
    end else begin
      beta_next_s = beta_sum_s[BETA_W-1:0];
    end
  end

  // Anneal schedule: count accepted samples, step beta once per period; restart wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beta_r <= BETA_RST;
      cnt_r  <= '0;
    end else if (anneal_restart) begin
      beta_r <= BETA_RST;
      cnt_r  <= '0;
    end else if (in_valid) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r  <= '0;
        beta_r <= beta_next_s;
      end else begin
        cnt_r  <= cnt_r + 1'b1;
      end
    end else begin
      beta_r <= beta_r;
      cnt_r  <= cnt_r;
    end
  end

  // S1 combinational scale: beta is zero-extended so it multiplies as a positive value.
  always_comb begin
    in_ext_s   = PROD_W'($signed(in_data));
    beta_ext_s = PROD_W'($signed({1'b0, beta_r}));
    prod_s     = in_ext_s * beta_ext_s;
    scaled_s   = prod_s >>> BETA_FRAC;
  end

  // S1 register: scaled field and its valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scaled_r <= '0;
      v1_r     <= 1'b0;
    end else begin
      scaled_r <= scaled_s;
      v1_r     <= in_valid;
    end
  end

  // S2 combinational clamp (hard-tanh) into RND_W+1 signed bits.
  always_comb begin
    act_s = scaled_r[RND_W:0];
    if (scaled_r > WIDE_HI) begin
      act_s = ACT_HI;
    end else if (scaled_r < WIDE_LO) begin
      act_s = ACT_LO;
    end else begin
      act_s = scaled_r[RND_W:0];
    end
  end

  // S2 register: clamped activation and its valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_r <= '0;
      v2_r  <= 1'b0;
    end else begin
      act_r <= act_s;
      v2_r  <= v1_r;
    end
  end

  // Uniform sample: low RND_W LFSR bits read as signed, sign-extended by one bit.
  assign rnd_s    = {lfsr_s[RND_W-1], lfsr_s[RND_W-1:0]};
  assign unused_s = ^lfsr_s[LFSR_W-1:RND_W];

  // S3 decide: new spin when a sample arrives, otherwise hold m_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_out     <= 1'b1;
      out_valid <= 1'b0;
    end else if (v2_r) begin
      m_out     <= (act_r > rnd_s);
      out_valid <= 1'b1;
    end else begin
      m_out     <= m_out;
      out_valid <= 1'b0;
    end
  end

  // The LFSR steps only after its value has been consumed by a valid S3 sample.
  pbit_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (v2_r),
    .seed  (LFSR_SEED),
    .state (lfsr_s)
  );

endmodule

// File: tb/tb_pbit_update.sv
// tb_pbit_update: scoreboard bench for pbit_update. The driver pushes the
// expected spin of every accepted sample; a negedge monitor pops and compares
// whenever out_valid is high, and checks m_out holds on idle cycles.
module tb_pbit_update;

  localparam int          P_PERIOD = 4;
  localparam int          P_STEP   = 4;
  localparam int          P_MAX    = 28;
  localparam int          P_INIT   = 16;
  localparam logic [15:0] P_SEED   = 16'hACE1;

  typedef struct {
    logic m;
    int   issue;
    logic noise;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic        anneal_restart = 1'b0;
  logic        m_out;
  logic        out_valid;
  logic [7:0]  beta_out;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          ones = 0;
  logic        rst_edge = 1'b1;
  logic        prev_m = 1'b1;
  logic        noise_phase = 1'b0;

  logic [15:0] mlfsr = P_SEED;
  int          mbeta = P_INIT;
  int          mcnt = 0;

  pbit_update #(
    .ANNEAL_PERIOD (P_PERIOD),
    .BETA_STEP     (P_STEP),
    .BETA_MAX      (P_MAX),
    .BETA_INIT     (P_INIT),
    .LFSR_SEED     (P_SEED)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .anneal_restart (anneal_restart),
    .m_out          (m_out),
    .out_valid      (out_valid),
    .beta_out       (beta_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Spin from field, beta and LFSR state: scale, floor-shift, clamp, compare.
  function automatic logic model_m(input int data, input int beta, input logic [15:0] l);
    longint p;
    int     r;
    p = longint'(data) * longint'(beta);
    p = p >>> 4;
    if (p > 2048) p = 2048;
    else if (p < -2048) p = -2048;
    r = int'(l[10:0]) - (l[11] ? 2048 : 0);
    return (p > longint'(r));
  endfunction

  // One clock: drive inputs, then update the model at the sampling edge.
  // forced < 0 takes the expected spin from the model, otherwise it is the hand value.
  task automatic tick(input logic v, input int data, input logic rs, input logic rn, input int forced);
    exp_t e;
    int   issue_c;
    in_valid       = v;
    in_data        = 16'(data);
    anneal_restart = rs;
    rst_n          = rn;
    issue_c        = cyc;
    @(posedge clk);
    cyc = cyc + 1;
    if (!rn) begin
      q.delete();
      mlfsr    = P_SEED;
      mbeta    = P_INIT;
      mcnt     = 0;
      rst_edge = 1'b1;
    end else begin
      rst_edge = 1'b0;
      if (v) begin
        e.m     = (forced < 0) ? model_m(data, mbeta, mlfsr) : forced[0];
        e.issue = issue_c;
        e.noise = noise_phase;
        q.push_back(e);
        mlfsr = model_lfsr_next(mlfsr);
        if (mcnt == P_PERIOD - 1) begin
          mcnt  = 0;
          mbeta = (mbeta + P_STEP > P_MAX) ? P_MAX : mbeta + P_STEP;
        end else begin
          mcnt = mcnt + 1;
        end
      end
      if (rs) begin
        mbeta = P_INIT;
        mcnt  = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b0, 1'b1, -1);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare every out_valid against the scoreboard; idle cycles must hold m_out.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL spurious_out_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("latency", cyc - e.issue, 3);
        chk("m_out", int'(m_out), int'(e.m));
        if (e.noise && m_out === 1'b1) ones = ones + 1;
      end
    end else if (!rst_edge) begin
      chk("m_out_hold", int'(m_out), int'(prev_m));
    end
    if (q.size() > 0 && cyc > q[0].issue + 3) begin
      e = q.pop_front();
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL overdue_output: got none expected out_valid at cycle %0d", e.issue + 3);
    end
    prev_m = m_out;
  end

  int beta_tab[20] = '{16, 16, 16, 20, 20, 20, 20, 24, 24, 24,
                       24, 28, 28, 16, 16, 16, 16, 20, 20, 20};
  int gap_pat[7] = '{1, 0, 1, 1, 0, 0, 1};

  initial begin
    // Reset held two cycles with in_valid high: nothing may enter the pipe.
    tick(1'b1, 5000, 1'b0, 1'b0, -1);
    tick(1'b1, 5000, 1'b0, 1'b0, -1);
    chk("reset_m_out", int'(m_out), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_beta", int'(beta_out), 16);

    // Anneal schedule, 20 back-to-back saturating samples, restart on #14.
    for (int k = 1; k <= 20; k++) begin
      tick(1'b1, 5000, (k == 14), 1'b1, 1);
      chk("beta_sched", int'(beta_out), beta_tab[k-1]);
    end
    idle(4);

    // Saturation: large fields decide regardless of the random sample.
    for (int k = 0; k < 100; k++) tick(1'b1, 5000, 1'b0, 1'b1, 1);
    for (int k = 0; k < 100; k++) tick(1'b1, -5000, 1'b0, 1'b1, 0);
    idle(4);

    // Unbiased noise from a fresh LFSR: zero field, 4096 samples.
    tick(1'b0, 0, 1'b0, 1'b0, -1);
    noise_phase = 1'b1;
    for (int k = 0; k < 4096; k++) tick(1'b1, 0, 1'b0, 1'b1, -1);
    noise_phase = 1'b0;
    idle(4);
    checks = checks + 1;
    if (ones < 1920 || ones > 2176) begin
      errors = errors + 1;
      $display("FAIL noise_balance: got %0d ones expected 2048+/-128", ones);
    end

    // Gaps: bring beta to 24, then a sparse pattern with field 100 (scaled 150).
    tick(1'b0, 0, 1'b0, 1'b0, -1);
    for (int k = 0; k < 8; k++) tick(1'b1, 0, 1'b0, 1'b1, -1);
    chk("beta_before_gaps", int'(beta_out), 24);
    for (int k = 0; k < 7; k++) tick(gap_pat[k] != 0, 100, 1'b0, 1'b1, -1);
    idle(4);
    for (int k = 0; k < 6; k++) tick(1'b1, 100, 1'b0, 1'b1, -1);
    idle(4);

    // Mid-stream reset: three samples, the last one alongside rst_n low.
    for (int k = 0; k < 5; k++) tick(1'b1, 0, 1'b0, 1'b1, -1);
    idle(4);
    tick(1'b1, 0, 1'b0, 1'b1, -1);
    tick(1'b1, 0, 1'b0, 1'b1, -1);
    tick(1'b1, 0, 1'b0, 1'b0, -1);
    chk("midreset_out_valid", int'(out_valid), 0);
    chk("midreset_beta", int'(beta_out), 16);
    idle(4);
    for (int k = 0; k < 8; k++) tick(1'b1, 0, 1'b0, 1'b1, -1);
    idle(5);

    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
